// File: rtl/ball_motion_ctrl.sv
// rtl/ball_motion_ctrl.sv - per-ball velocity controller: cushion reflection, friction and cue strikes
// Drives the ball's velocity-write port once per frame and on accepted strikes.
module ball_motion_ctrl #(
   parameter int TABLE_LEFT      = 32,
   parameter int TABLE_RIGHT     = 607,
   parameter int TABLE_TOP       = 32,
   parameter int TABLE_BOTTOM    = 447,
   parameter int BALL_SIZE       = 16,
   parameter int FRICTION_FRAMES = 40,
   parameter int FRICTION_STEP   = 1
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic signed [10:0] topLeftPosX,
   input  logic signed [10:0] topLeftPosY,
   input  logic signed [10:0] inVelocityX,
   input  logic signed [10:0] inVelocityY,
   input  logic               strikeValid,
   input  logic signed [10:0] strikeVelX,
   input  logic signed [10:0] strikeVelY,
   output logic               velocityWriteEnable,
   output logic signed [10:0] outVelocityX,
   output logic signed [10:0] outVelocityY,
   output logic               strikeAck,
   output logic               wallHitX,
   output logic               wallHitY,
   output logic               ballStopped
);

   localparam int CNT_W = (FRICTION_FRAMES > 1) ? $clog2(FRICTION_FRAMES) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRICTION_FRAMES - 1);
   localparam logic signed [11:0] LEFT_E   = 12'(TABLE_LEFT);
   localparam logic signed [11:0] RIGHT_E  = 12'(TABLE_RIGHT);
   localparam logic signed [11:0] TOP_E    = 12'(TABLE_TOP);
   localparam logic signed [11:0] BOTTOM_E = 12'(TABLE_BOTTOM);
   localparam logic signed [11:0] SPAN     = 12'(BALL_SIZE - 1);
   localparam logic signed [10:0] STEP_C   = 11'(FRICTION_STEP);

   typedef enum logic [2:0] {IDLE, SAMPLE, EVAL, WRITE, STRIKE} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   frame_cnt_q;
   logic               friction_q;
   logic signed [10:0] pos_x_q, pos_y_q;
   logic signed [10:0] vel_x_q, vel_y_q;
   logic               vwe_q, ack_q, hit_x_q, hit_y_q, stopped_q;
   logic signed [10:0] out_x_q, out_y_q;

   logic signed [11:0] pos_x_ext, pos_y_ext, far_x, far_y;
   logic               hit_x_d, hit_y_d;
   logic signed [10:0] refl_x, refl_y, res_x_d, res_y_d;

   // The only negation that overflows 11 bits is -1024; clamp it to the top of range.
   function automatic logic signed [10:0] sat_neg(input logic signed [10:0] v);
      if (v == 11'sh400) return 11'sh3FF;
      return -v;
   endfunction

   function automatic logic signed [10:0] toward_zero(input logic signed [10:0] v);
      if (v > STEP_C)  return v - STEP_C;
      if (v < -STEP_C) return v + STEP_C;
      return '0;
   endfunction

   // Reflection only fires when moving into the cushion, so an overlapping ball never bounces twice.
   always_comb begin
      pos_x_ext = 12'(pos_x_q);
      pos_y_ext = 12'(pos_y_q);
      far_x     = pos_x_ext + SPAN;
      far_y     = pos_y_ext + SPAN;
      hit_x_d   = ((pos_x_ext <= LEFT_E) && (vel_x_q < 0)) || ((far_x >= RIGHT_E) && (vel_x_q > 0));
      hit_y_d   = ((pos_y_ext <= TOP_E) && (vel_y_q < 0)) || ((far_y >= BOTTOM_E) && (vel_y_q > 0));
      refl_x    = hit_x_d ? sat_neg(vel_x_q) : vel_x_q;
      refl_y    = hit_y_d ? sat_neg(vel_y_q) : vel_y_q;
      res_x_d   = friction_q ? toward_zero(refl_x) : refl_x;
      res_y_d   = friction_q ? toward_zero(refl_y) : refl_y;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= IDLE;
         frame_cnt_q <= '0;
         friction_q  <= 1'b0;
         pos_x_q     <= '0;
         pos_y_q     <= '0;
         vel_x_q     <= '0;
         vel_y_q     <= '0;
         vwe_q       <= 1'b0;
         ack_q       <= 1'b0;
         hit_x_q     <= 1'b0;
         hit_y_q     <= 1'b0;
         stopped_q   <= 1'b1;
         out_x_q     <= '0;
         out_y_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (startOfFrame) begin
                  state_q <= SAMPLE;
               end else if (strikeValid && stopped_q) begin
                  state_q <= STRIKE;
                  vwe_q   <= 1'b1;
                  ack_q   <= 1'b1;
                  out_x_q <= strikeVelX;
                  out_y_q <= strikeVelY;
               end
            end
            SAMPLE: begin
               pos_x_q     <= topLeftPosX;
               pos_y_q     <= topLeftPosY;
               vel_x_q     <= inVelocityX;
               vel_y_q     <= inVelocityY;
               stopped_q   <= (inVelocityX == '0) && (inVelocityY == '0);
               friction_q  <= (frame_cnt_q == CNT_LAST);
               frame_cnt_q <= (frame_cnt_q == CNT_LAST) ? '0 : frame_cnt_q + CNT_W'(1);
               state_q     <= EVAL;
            end
            EVAL: begin
               vwe_q   <= (res_x_d != vel_x_q) || (res_y_d != vel_y_q);
               out_x_q <= res_x_d;
               out_y_q <= res_y_d;
               hit_x_q <= hit_x_d;
               hit_y_q <= hit_y_d;
               state_q <= WRITE;
            end
            WRITE: begin
               vwe_q   <= 1'b0;
               hit_x_q <= 1'b0;
               hit_y_q <= 1'b0;
               state_q <= IDLE;
            end
            STRIKE: begin
               vwe_q     <= 1'b0;
               ack_q     <= 1'b0;
               stopped_q <= (out_x_q == '0) && (out_y_q == '0);
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign velocityWriteEnable = vwe_q;
   assign outVelocityX        = out_x_q;
   assign outVelocityY        = out_y_q;
   assign strikeAck           = ack_q;
   assign wallHitX            = hit_x_q;
   assign wallHitY            = hit_y_q;
   assign ballStopped         = stopped_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb/tb_ball_motion_ctrl.sv - directed scoreboard bench for ball_motion_ctrl
module tb_ball_motion_ctrl;

   localparam int L = 32, R = 607, T = 32, B = 447, SZ = 16, FF = 40;

   logic clk = 1'b0;
   logic resetN = 1'b0;
   logic startOfFrame = 1'b0;
   logic signed [10:0] pos_x = '0, pos_y = '0, vel_x = '0, vel_y = '0;
   logic strikeValid = 1'b0;
   logic signed [10:0] s_x = '0, s_y = '0;
   logic vwe, ack, hit_x, hit_y, stopped;
   logic signed [10:0] out_x, out_y;

   int tests = 0;
   int fails = 0;
   int frame_cnt = 0;
   int writes = 0;

   typedef struct {
      logic we;
      logic hx;
      logic hy;
      int   vx;
      int   vy;
   } exp_t;
   exp_t sb[$];

   ball_motion_ctrl dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .topLeftPosX(pos_x), .topLeftPosY(pos_y),
      .inVelocityX(vel_x), .inVelocityY(vel_y),
      .strikeValid(strikeValid), .strikeVelX(s_x), .strikeVelY(s_y),
      .velocityWriteEnable(vwe), .outVelocityX(out_x), .outVelocityY(out_y),
      .strikeAck(ack), .wallHitX(hit_x), .wallHitY(hit_y), .ballStopped(stopped)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int fric(input int v);
      if (v > 0) return (v > 1) ? v - 1 : 0;
      if (v < 0) return (v < -1) ? v + 1 : 0;
      return 0;
   endfunction

   function automatic exp_t model(input int px, input int py, input int vx, input int vy, input bit wrap);
      exp_t e;
      int nx = vx;
      int ny = vy;
      e.hx = (px <= L && vx < 0) || (px + SZ - 1 >= R && vx > 0);
      e.hy = (py <= T && vy < 0) || (py + SZ - 1 >= B && vy > 0);
      if (e.hx) nx = (vx == -1024) ? 1023 : -vx;
      if (e.hy) ny = (vy == -1024) ? 1023 : -vy;
      if (wrap) begin
         nx = fric(nx);
         ny = fric(ny);
      end
      e.we = (nx != vx) || (ny != vy);
      e.vx = nx;
      e.vy = ny;
      return e;
   endfunction

   task automatic run_frame(input string tag, input int px, input int py, input int vx, input int vy);
      exp_t e;
      bit wrap = (frame_cnt == FF - 1);
      frame_cnt = wrap ? 0 : frame_cnt + 1;
      sb.push_back(model(px, py, vx, vy, wrap));
      pos_x = 11'(px); pos_y = 11'(py); vel_x = 11'(vx); vel_y = 11'(vy);
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
      tick();
      e = sb.pop_front();
      if (vwe === 1'b1) writes++;
      chk({tag, "_we"}, int'(vwe), int'(e.we));
      if (e.we) begin
         chk({tag, "_vx"}, int'(out_x), e.vx);
         chk({tag, "_vy"}, int'(out_y), e.vy);
      end
      chk({tag, "_hitx"}, int'(hit_x), int'(e.hx));
      chk({tag, "_hity"}, int'(hit_y), int'(e.hy));
      tick();
      chk({tag, "_we_end"}, int'(vwe), 0);
      chk({tag, "_stopped"}, int'(stopped), int'(vx == 0 && vy == 0));
   endtask

   initial begin
      int acks;
      int ack_cyc;
      tick();
      tick();
      chk("rst_we", int'(vwe), 0);
      chk("rst_vx", int'(out_x), 0);
      chk("rst_vy", int'(out_y), 0);
      chk("rst_ack", int'(ack), 0);
      chk("rst_hits", int'({hit_x, hit_y}), 0);
      chk("rst_stopped", int'(stopped), 1);
      resetN = 1'b1;
      tick();

      run_frame("idle0", 300, 200, 0, 0);
      run_frame("idle1", 300, 200, 0, 0);
      run_frame("left", 30, 200, -5, 3);
      run_frame("right", 600, 200, 7, 0);
      run_frame("right_again", 600, 200, -7, 0);

      // strike on a stopped ball
      run_frame("stop", 300, 200, 0, 0);
      s_x = 11'sd20; s_y = -11'sd12; strikeValid = 1'b1;
      tick();
      chk("strike_ack", int'(ack), 1);
      chk("strike_we", int'(vwe), 1);
      chk("strike_vx", int'(out_x), 20);
      chk("strike_vy", int'(out_y), -12);
      strikeValid = 1'b0;
      tick();
      chk("strike_ack_end", int'(ack), 0);
      chk("strike_stopped", int'(stopped), 0);

      // strike held off while the ball moves
      run_frame("moving", 300, 200, 20, -12);
      strikeValid = 1'b1;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (ack === 1'b1) acks++;
      end
      strikeValid = 1'b0;
      chk("moving_no_ack", acks, 0);

      run_frame("corner", 32, 32, -1024, -3);

      // simultaneous frame and strike: frame sequence runs first
      run_frame("stop2", 300, 200, 0, 0);
      frame_cnt = (frame_cnt == FF - 1) ? 0 : frame_cnt + 1;
      pos_x = 11'sd300; pos_y = 11'sd200; vel_x = '0; vel_y = '0;
      s_x = 11'sd5; s_y = 11'sd6;
      startOfFrame = 1'b1; strikeValid = 1'b1;
      tick();
      startOfFrame = 1'b0;
      ack_cyc = -1;
      for (int c = 1; c <= 8 && ack_cyc < 0; c++) begin
         if (ack === 1'b1) begin
            ack_cyc = c;
            chk("both_we", int'(vwe), 1);
            chk("both_vx", int'(out_x), 5);
            chk("both_vy", int'(out_y), 6);
            strikeValid = 1'b0;
         end else begin
            tick();
         end
      end
      strikeValid = 1'b0;
      chk("both_ack_seen", int'(ack_cyc > 3), 1);
      tick();
      chk("both_ack_end", int'(ack), 0);

      // reset during EVAL drops the pending write
      pos_x = 11'sd30; pos_y = 11'sd200; vel_x = -11'sd5; vel_y = '0;
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
      resetN = 1'b0;
      #1;
      chk("midrst_we", int'(vwe), 0);
      tick();
      resetN = 1'b1;
      tick();
      chk("midrst_we2", int'(vwe), 0);
      chk("midrst_stopped", int'(stopped), 1);
      frame_cnt = 0;

      // friction: one write on the 40th frame after reset
      writes = 0;
      for (int f = 0; f < FF; f++) run_frame("fric", 300, 200, 1, -2);
      chk("fric_writes", writes, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
